// File: rtl/jt1943_prot_ctrl.sv
// -----------------------------------------------------------------------------
// jt1943_prot_ctrl
//
// Sequencer for the 1943 copy-protection lookup. It sits between the main Z80
// bus and the protection table:
//   - latches a CPU command byte and drives it to the table as the key
//   - waits LATENCY clock-enable ticks to model the protection MCU's response
//     time
//   - captures the table answer into a result register
//   - reports busy/ready/overrun status back to the CPU
//
// Parameters:
//   LATENCY   cen ticks spent in WAIT before capture (legal range 2..15)
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset (overrides cen)
//   cen        clock enable; all state changes happen only on cen edges
//   cpu_cs     protection port select
//   cpu_wr_n   0 = write, 1 = read
//   cpu_addr   0 = data port, 1 = status port
//   cpu_din    CPU write data
//   cpu_dout   registered read data
//   lut_key    key to the protection table, held until the next command
//   lut_data   table answer
//   busy       command in flight
//   irq        result-ready interrupt request
//
// Build option:
//   JT1943_PROT_IRQ_EN  when defined, irq is a register that rises with ready
//                       and is cleared by a data read or a status clear.
//                       When undefined, irq is tied low.
//
// States:
//   IDLE  | no command in flight; a data-port write is accepted here
//   ISSUE | key is on lut_key; loads the wait counter
//   WAIT  | counting down cen ticks; captures lut_data when cnt reaches 0
// -----------------------------------------------------------------------------
module jt1943_prot_ctrl #(
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cpu_cs,
    input  logic       cpu_wr_n,
    input  logic       cpu_addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic [7:0] lut_key,
    input  logic [7:0] lut_data,
    output logic       busy,
    output logic       irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] key, key_nxt;
    logic [7:0] result, result_nxt;
    logic [7:0] dout_nxt;
    logic       ready, ready_nxt;
    logic       overrun, overrun_nxt;
    logic       capture;

    // Bus decode. Strobes only take effect through the cen-gated registers,
    // so strobes sampled with cen=0 are ignored.
    logic cmd_wr, stat_wr, data_rd, stat_rd;
    logic clr_flags, abort;

    assign cmd_wr    = cpu_cs & ~cpu_wr_n & ~cpu_addr;
    assign stat_wr   = cpu_cs & ~cpu_wr_n &  cpu_addr;
    assign data_rd   = cpu_cs &  cpu_wr_n & ~cpu_addr;
    assign stat_rd   = cpu_cs &  cpu_wr_n &  cpu_addr;
    assign clr_flags = stat_wr & cpu_din[7];
    assign abort     = stat_wr & cpu_din[6];

    assign busy    = (state != ST_IDLE);
    assign lut_key = key;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            key      <= 8'h00;
            result   <= 8'h00;
            ready    <= 1'b0;
            overrun  <= 1'b0;
            cpu_dout <= 8'h00;
        end else if (cen) begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            key      <= key_nxt;
            result   <= result_nxt;
            ready    <= ready_nxt;
            overrun  <= overrun_nxt;
            cpu_dout <= dout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        key_nxt     = key;
        result_nxt  = result;
        capture     = 1'b0;
        overrun_nxt = overrun;
        dout_nxt    = cpu_dout;

        case (state)
            ST_IDLE: begin
                if (cmd_wr) begin
                    key_nxt   = cpu_din;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
                cnt_nxt   = CNT_LOAD;
            end
            ST_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    capture    = 1'b1;
                    result_nxt = lut_data;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase

        // An abort wins over a capture due on the same edge.
        if (abort && state != ST_IDLE) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = 4'd0;
            capture    = 1'b0;
            result_nxt = result;
        end

        // Writes are only dropped (never queued) while a command is in flight.
        if (cmd_wr && state != ST_IDLE)
            overrun_nxt = 1'b1;
        else if (clr_flags)
            overrun_nxt = 1'b0;

        // Capture sets ready even if the same edge tries to clear it.
        if (capture)
            ready_nxt = 1'b1;
        else if (data_rd || clr_flags)
            ready_nxt = 1'b0;
        else
            ready_nxt = ready;

        // Reads return the pre-edge register contents.
        if (data_rd)
            dout_nxt = result;
        else if (stat_rd)
            dout_nxt = {5'b0, overrun, ready, busy};
    end

`ifdef JT1943_PROT_IRQ_EN
    logic irq_q;

    // Rises only on a 0->1 transition of ready; a set beats a same-edge clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else if (cen) begin
            if (capture && !ready)
                irq_q <= 1'b1;
            else if (data_rd || clr_flags)
                irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_jt1943_prot_ctrl.sv
module tb_jt1943_prot_ctrl;

    localparam int LAT = 4;
`ifdef JT1943_PROT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       cpu_cs = 1'b0;
    logic       cpu_wr_n = 1'b1;
    logic       cpu_addr = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic [7:0] cpu_dout;
    logic [7:0] lut_key;
    logic [7:0] lut_data;
    logic       busy;
    logic       irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] table_f(input logic [7:0] k);
        return k ^ 8'h39;
    endfunction

    assign lut_data = table_f(lut_key);

    jt1943_prot_ctrl #(.LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .cpu_cs   (cpu_cs),
        .cpu_wr_n (cpu_wr_n),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .lut_key  (lut_key),
        .lut_data (lut_data),
        .busy     (busy),
        .irq      (irq)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a command is just "ticks left until capture".
    logic       m_valid = 1'b0;
    int         m_left;
    logic [7:0] m_key, m_result, m_dout;
    logic       m_ready, m_ovr, m_irq;

    always @(posedge clk) begin
        logic busy_o, rdy_o, ovr_o;
        logic drd, srd, swr, cwr, cap, clr;
        if (rst) begin
            m_valid = 1'b1;
            m_left = 0; m_key = 0; m_result = 0; m_dout = 0;
            m_ready = 0; m_ovr = 0; m_irq = 0;
        end else if (cen && m_valid) begin
            busy_o = (m_left != 0);
            rdy_o  = m_ready;
            ovr_o  = m_ovr;
            cwr = cpu_cs && !cpu_wr_n && !cpu_addr;
            swr = cpu_cs && !cpu_wr_n &&  cpu_addr;
            drd = cpu_cs &&  cpu_wr_n && !cpu_addr;
            srd = cpu_cs &&  cpu_wr_n &&  cpu_addr;
            clr = swr && cpu_din[7];
            cap = 1'b0;
            if (drd) m_dout = m_result;
            if (srd) m_dout = {5'b0, ovr_o, rdy_o, busy_o};
            if (busy_o) begin
                if (swr && cpu_din[6]) m_left = 0;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) cap = 1'b1;
                end
            end
            if (cwr) begin
                if (!busy_o) begin
                    m_key  = cpu_din;
                    m_left = LAT + 1;
                end else m_ovr = 1'b1;
            end else if (clr) m_ovr = 1'b0;
            if (cap) m_result = table_f(m_key);
            m_ready = cap ? 1'b1 : ((drd || clr) ? 1'b0 : rdy_o);
            if (IRQ_ON) begin
                if (cap && !rdy_o) m_irq = 1'b1;
                else if (drd || clr) m_irq = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_dout", cpu_dout, m_dout);
            chk("m_key",  lut_key,  m_key);
            chk("m_busy", {7'b0, busy}, {7'b0, (m_left != 0)});
            chk("m_irq",  {7'b0, irq},  {7'b0, m_irq});
        end
    end

    task automatic cyc(input logic c, input logic cs, input logic wr_n,
                       input logic a, input logic [7:0] d);
        cen = c; cpu_cs = cs; cpu_wr_n = wr_n; cpu_addr = a; cpu_din = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();          cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00); endtask
    task automatic wr_data(input logic [7:0] d); cyc(1'b1, 1'b1, 1'b0, 1'b0, d); endtask
    task automatic wr_stat(input logic [7:0] d); cyc(1'b1, 1'b1, 1'b0, 1'b1, d); endtask
    task automatic rd_data();       cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00); endtask
    task automatic rd_stat();       cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00); endtask

    initial begin
        rst = 1'b1;
        idle(); idle();
        rst = 1'b0;

        // Reset state
        rd_stat();
        chk("rst_status", cpu_dout, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_irq",  {7'b0, irq},  8'h00);

        // Basic command, LATENCY=4
        wr_data(8'h24);
        chk("cmd_busy_k", {7'b0, busy}, 8'h01);
        chk("cmd_key", lut_key, 8'h24);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("cmd_busy_mid", {7'b0, busy}, 8'h01);
        end
        idle();
        chk("cmd_busy_done", {7'b0, busy}, 8'h00);
        chk("cmd_irq_set", {7'b0, irq}, {7'b0, IRQ_ON});
        rd_stat();
        chk("cmd_status_rdy", cpu_dout, 8'h02);
        rd_data();
        chk("cmd_result", cpu_dout, 8'h1d);
        chk("cmd_irq_clr", {7'b0, irq}, 8'h00);
        rd_stat();
        chk("cmd_status_clr", cpu_dout, 8'h00);

        // Overrun
        wr_data(8'h24);
        wr_data(8'h60);
        chk("ovr_key", lut_key, 8'h24);
        repeat (4) idle();
        chk("ovr_busy_done", {7'b0, busy}, 8'h00);
        rd_stat();
        chk("ovr_status", cpu_dout, 8'h06);
        wr_stat(8'h80);
        rd_stat();
        chk("ovr_status_clr", cpu_dout, 8'h00);
        rd_data();
        chk("ovr_result", cpu_dout, 8'h1d);

        // Abort
        wr_data(8'h01);
        idle();
        wr_stat(8'h40);
        chk("abort_busy", {7'b0, busy}, 8'h00);
        repeat (6) idle();
        rd_stat();
        chk("abort_status", cpu_dout, 8'h00);
        rd_data();
        chk("abort_result", cpu_dout, 8'h1d);
        wr_data(8'h55);
        chk("abort_new_busy", {7'b0, busy}, 8'h01);
        chk("abort_new_key", lut_key, 8'h55);
        repeat (5) idle();
        rd_data();
        chk("abort_new_result", cpu_dout, 8'h6c);

        // cen at 1-in-3 duty; bus activity without cen is ignored
        wr_data(8'h24);
        for (int n = 1; n <= 5; n++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom));
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hc0);
            idle();
            chk("cen_busy", {7'b0, busy}, {7'b0, (n < 5)});
        end
        chk("cen_key", lut_key, 8'h24);
        rd_data();
        chk("cen_result", cpu_dout, 8'h1d);

        // Reset during WAIT
        wr_data(8'h33);
        idle(); idle();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        rst = 1'b0;
        chk("rstw_dout", cpu_dout, 8'h00);
        chk("rstw_key",  lut_key,  8'h00);
        chk("rstw_busy", {7'b0, busy}, 8'h00);
        chk("rstw_irq",  {7'b0, irq},  8'h00);
        repeat (6) idle();
        rd_stat();
        chk("rstw_status", cpu_dout, 8'h00);

        // Capture and data read on the same edge
        wr_data(8'h24);
        repeat (4) idle();
        rd_data();
        chk("same_dout_old", cpu_dout, 8'h00);
        chk("same_irq", {7'b0, irq}, {7'b0, IRQ_ON});
        rd_stat();
        chk("same_status", cpu_dout, 8'h02);
        rd_data();
        chk("same_result", cpu_dout, 8'h1d);
        chk("same_irq_clr", {7'b0, irq}, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            cyc(($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
                1'($urandom), 8'($urandom));
        end
        rst = 1'b0;
        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
